rf_multiport_sb: RTL and testbench

Parametrised integer register file for the RISC-V pipeline with N combinational read ports, same-cycle write-to-read bypass, hardwired x0, a pending-write scoreboard for hazard detection, and a registered write-trace port. It sits between decode (read and reserve) and writeback (write and clear). It replaces the single-write, two-read negedge register file with a posedge, bypassed design.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 65 ++++++
 rtl/rf_multiport_sb.sv | 109 ++++++++++
 tb/tb_rf_multiport_sb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and data types for the bypassed multi-port register file.
package rf_pkg;

    localparam int unsigned RF_DATA_WIDTH    = 32;
    localparam int unsigned RF_ADDRESS_WIDTH = 5;
    localparam int unsigned RF_NUM_REGS      = 32;
    localparam int unsigned RF_NUM_RD_PORTS  = 2;

    typedef logic [RF_ADDRESS_WIDTH-1:0] rf_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0]    rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on reserve, cleared on
// writeback or flush, with a registered write-after-write reserve warning.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
    parameter int unsigned NUM_REGS      = RF_NUM_REGS,
    parameter int unsigned ZERO_REG      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_eff,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDRESS_WIDTH-1:0] rsv_addr,
    input  logic                     sb_flush,
    output logic [NUM_REGS-1:0]      busy,
    output logic                     err_waw
);

    localparam logic [ADDRESS_WIDTH:0] LP_LIMIT = (ADDRESS_WIDTH+1)'(NUM_REGS);

    logic [NUM_REGS-1:0] r_busy;
    logic                r_err;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_rsv_eff;
    logic                w_waw_hit;

    assign w_rsv_eff = rsv_en && ({1'b0, rsv_addr} < LP_LIMIT)
                       && !((ZERO_REG != 0) && (rsv_addr == '0));

    // A bit already pending and not released by this cycle's write or flush.
    assign w_waw_hit = w_rsv_eff && r_busy[rsv_addr] && !sb_flush
                       && !(wr_eff && (wr_addr == rsv_addr));

    // Clear first (flush or writeback), then reserve, so a same-cycle reserve wins.
    always_comb begin
        w_busy_next = r_busy;
        if (sb_flush) begin
            w_busy_next = '0;
        end else if (wr_eff) begin
            w_busy_next[wr_addr] = 1'b0;
        end
        if (w_rsv_eff) begin
            w_busy_next[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_err  <= w_waw_hit;
        end
    end

    assign busy    = r_busy;
    assign err_waw = r_err;

endmodule

// File: rtl/rf_multiport_sb.sv
// Posedge register file with N combinational read ports, write-to-read bypass,
// optional hardwired x0, pending-write scoreboard and a registered write trace.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
    parameter int unsigned NUM_REGS      = RF_NUM_REGS,
    parameter int unsigned NUM_RD_PORTS  = RF_NUM_RD_PORTS,
    parameter int unsigned ZERO_REG      = 1,
    parameter int unsigned BYPASS        = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr [NUM_RD_PORTS],
    output logic [DATA_WIDTH-1:0]    rd_data [NUM_RD_PORTS],
    output logic [NUM_RD_PORTS-1:0]  rd_busy,
    input  logic                     rsv_en,
    input  logic [ADDRESS_WIDTH-1:0] rsv_addr,
    input  logic                     sb_flush,
    output logic                     trc_valid,
    output logic [ADDRESS_WIDTH-1:0] trc_addr,
    output logic [DATA_WIDTH-1:0]    trc_data,
    output logic                     err_waw
);

    localparam logic [ADDRESS_WIDTH:0] LP_LIMIT = (ADDRESS_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];
    logic                     r_trc_valid;
    logic [ADDRESS_WIDTH-1:0] r_trc_addr;
    logic [DATA_WIDTH-1:0]    r_trc_data;
    logic                     w_wr_eff;
    logic [NUM_REGS-1:0]      w_busy;

    assign w_wr_eff = wr_en && ({1'b0, wr_addr} < LP_LIMIT)
                      && !((ZERO_REG != 0) && (wr_addr == '0));

    rf_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_REGS      (NUM_REGS),
        .ZERO_REG      (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_eff   (w_wr_eff),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .sb_flush (sb_flush),
        .busy     (w_busy),
        .err_waw  (err_waw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_eff) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trc_valid <= 1'b0;
            r_trc_addr  <= '0;
            r_trc_data  <= '0;
        end else begin
            r_trc_valid <= w_wr_eff;
            if (w_wr_eff) begin
                r_trc_addr <= wr_addr;
                r_trc_data <= wr_data;
            end
        end
    end

    assign trc_valid = r_trc_valid;
    assign trc_addr  = r_trc_addr;
    assign trc_data  = r_trc_data;

    for (genvar gp = 0; gp < NUM_RD_PORTS; gp++) begin : g_rd
        logic w_valid;
        logic w_hit;

        assign w_valid = ({1'b0, rd_addr[gp]} < LP_LIMIT)
                         && !((ZERO_REG != 0) && (rd_addr[gp] == '0));
        assign w_hit   = w_wr_eff && (wr_addr == rd_addr[gp]);

        always_comb begin
            rd_data[gp] = '0;
            rd_busy[gp] = 1'b0;
            if (w_valid) begin
                if ((BYPASS != 0) && w_hit) begin
                    rd_data[gp] = wr_data;
                end else begin
                    rd_data[gp] = r_regs[rd_addr[gp]];
                end
                // The writeback landing this cycle releases the hazard immediately.
                rd_busy[gp] = w_busy[rd_addr[gp]] && !w_hit;
            end
        end
    end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Bench for rf_multiport_sb: directed vector table plus randomized traffic on two
// differently parameterised instances, checked against a behavioural model.
module tb_rf_multiport_sb;
    import rf_pkg::*;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        sb_flush;

    logic [4:0]  rdA_addr [2];
    logic [31:0] rdA_data [2];
    logic [1:0]  rdA_busy;
    logic        trcA_valid, errA;
    logic [4:0]  trcA_addr;
    logic [31:0] trcA_data;

    logic [4:0]  rdB_addr [3];
    logic [31:0] rdB_data [3];
    logic [2:0]  rdB_busy;
    logic        trcB_valid, errB;
    logic [4:0]  trcB_addr;
    logic [31:0] trcB_data;

    int checks = 0;
    int errors = 0;

    rf_multiport_sb #(
        .DATA_WIDTH (32), .ADDRESS_WIDTH (5), .NUM_REGS (32),
        .NUM_RD_PORTS (2), .ZERO_REG (1), .BYPASS (1)
    ) dut_a (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_addr (rdA_addr), .rd_data (rdA_data), .rd_busy (rdA_busy),
        .rsv_en (rsv_en), .rsv_addr (rsv_addr), .sb_flush (sb_flush),
        .trc_valid (trcA_valid), .trc_addr (trcA_addr), .trc_data (trcA_data),
        .err_waw (errA)
    );

    rf_multiport_sb #(
        .DATA_WIDTH (32), .ADDRESS_WIDTH (5), .NUM_REGS (24),
        .NUM_RD_PORTS (3), .ZERO_REG (0), .BYPASS (0)
    ) dut_b (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_addr (rdB_addr), .rd_data (rdB_data), .rd_busy (rdB_busy),
        .rsv_en (rsv_en), .rsv_addr (rsv_addr), .sb_flush (sb_flush),
        .trc_valid (trcB_valid), .trc_addr (trcB_addr), .trc_data (trcB_data),
        .err_waw (errB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state, one slot per instance.
    logic [31:0] mreg  [2][32];
    bit          mbusy [2][32];
    bit          mtv [2];
    logic [4:0]  mta [2];
    logic [31:0] mtd [2];
    bit          merr [2];
    bit          model_valid = 1'b0;

    function automatic int nr(int k);  return (k == 0) ? 32 : 24; endfunction
    function automatic bit zr(int k);  return (k == 0);           endfunction
    function automatic bit bp(int k);  return (k == 0);           endfunction

    function automatic bit wr_effective(int k);
        return wr_en && (int'(wr_addr) < nr(k)) && !(zr(k) && wr_addr == 0);
    endfunction

    function automatic bit rsv_effective(int k);
        return rsv_en && (int'(rsv_addr) < nr(k)) && !(zr(k) && rsv_addr == 0);
    endfunction

    function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
        if ((zr(k) && a == 0) || int'(a) >= nr(k)) return 32'h0;
        if (bp(k) && wr_effective(k) && wr_addr == a) return wr_data;
        return mreg[k][a];
    endfunction

    function automatic bit exp_busy(int k, logic [4:0] a);
        if (int'(a) >= nr(k)) return 1'b0;
        return mbusy[k][a] && !(wr_effective(k) && wr_addr == a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic model_compare();
        logic [31:0] ard [4];
        logic        abz [4];
        logic [4:0]  aad [4];
        int          np;
        logic        atv, aer;
        logic [4:0]  ata;
        logic [31:0] atd;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                np = 2;
                for (int p = 0; p < 2; p++) begin
                    ard[p] = rdA_data[p]; abz[p] = rdA_busy[p]; aad[p] = rdA_addr[p];
                end
                atv = trcA_valid; ata = trcA_addr; atd = trcA_data; aer = errA;
            end else begin
                np = 3;
                for (int p = 0; p < 3; p++) begin
                    ard[p] = rdB_data[p]; abz[p] = rdB_busy[p]; aad[p] = rdB_addr[p];
                end
                atv = trcB_valid; ata = trcB_addr; atd = trcB_data; aer = errB;
            end
            for (int p = 0; p < np; p++) begin
                check($sformatf("m%0d_rd_data%0d@%0d", k, p, aad[p]), ard[p], exp_rd(k, aad[p]));
                check($sformatf("m%0d_rd_busy%0d@%0d", k, p, aad[p]), {31'b0, abz[p]},
                      {31'b0, exp_busy(k, aad[p])});
            end
            check($sformatf("m%0d_trc_valid", k), {31'b0, atv}, {31'b0, mtv[k]});
            check($sformatf("m%0d_trc_addr", k), {27'b0, ata}, {27'b0, mta[k]});
            check($sformatf("m%0d_trc_data", k), atd, mtd[k]);
            check($sformatf("m%0d_err_waw", k), {31'b0, aer}, {31'b0, merr[k]});
        end
    endtask

    task automatic model_step();
        bit eff, reff, nerr;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) begin
                    mreg[k][r] = 32'h0;
                    mbusy[k][r] = 1'b0;
                end
                mtv[k] = 1'b0; mta[k] = 5'h0; mtd[k] = 32'h0; merr[k] = 1'b0;
            end else begin
                eff  = wr_effective(k);
                reff = rsv_effective(k);
                nerr = reff && mbusy[k][rsv_addr] && !sb_flush && !(eff && wr_addr == rsv_addr);
                mtv[k] = eff;
                if (eff) begin
                    mta[k] = wr_addr;
                    mtd[k] = wr_data;
                    mreg[k][wr_addr] = wr_data;
                end
                if (sb_flush) begin
                    for (int r = 0; r < 32; r++) mbusy[k][r] = 1'b0;
                end
                if (eff) mbusy[k][wr_addr] = 1'b0;
                if (reff) mbusy[k][rsv_addr] = 1'b1;
                merr[k] = nerr;
            end
        end
        if (rst) model_valid = 1'b1;
    endtask

    // Inputs are already applied just after a negedge; compare, clock, update model.
    task automatic cycle();
        #2;
        if (model_valid) model_compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          rsv;
        logic [4:0]  ra;
        bit          fl;
        logic [4:0]  rd;
        bit          chk;
        logic [31:0] e_rd;
        bit          e_busy;
        bit          e_tv;
        logic [4:0]  e_ta;
        logic [31:0] e_td;
        bit          e_err;
        logic [31:0] e_rdb;
    } vec_t;

    vec_t tbl [19];

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; sb_flush = 1'b0;
        rdA_addr[0] = '0; rdA_addr[1] = '0;
        rdB_addr[0] = '0; rdB_addr[1] = '0; rdB_addr[2] = '0;

        //          rst we wa wd           rsv ra fl rd chk e_rd         bz tv ta td           er e_rdb
        tbl[0]  = '{1, 0, 0, 32'h0,        0, 0, 0, 3, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        tbl[1]  = '{0, 0, 0, 32'h0,        0, 0, 0, 3, 1, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        tbl[2]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,        0, 32'h0};
        tbl[3]  = '{0, 0, 0, 32'h0,        0, 0, 0, 5, 1, 32'hDEADBEEF, 0, 1, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF};
        tbl[4]  = '{0, 1, 0, 32'h1234,     0, 0, 0, 0, 1, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        tbl[5]  = '{0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0,        0, 0, 0, 32'h0,        0, 32'h1234};
        tbl[6]  = '{0, 0, 0, 32'h0,        1, 7, 0, 7, 1, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        tbl[7]  = '{0, 0, 0, 32'h0,        0, 0, 0, 7, 1, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0};
        tbl[8]  = '{0, 1, 7, 32'h77,       0, 0, 0, 7, 1, 32'h77,       0, 0, 0, 32'h0,        0, 32'h0};
        tbl[9]  = '{0, 1, 7, 32'h88,       1, 7, 0, 7, 1, 32'h88,       0, 1, 7, 32'h77,       0, 32'h77};
        tbl[10] = '{0, 0, 0, 32'h0,        0, 0, 0, 7, 1, 32'h88,       1, 1, 7, 32'h88,       0, 32'h88};
        tbl[11] = '{0, 0, 0, 32'h0,        1, 9, 0, 9, 1, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        tbl[12] = '{0, 0, 0, 32'h0,        1, 9, 0, 9, 1, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0};
        tbl[13] = '{0, 0, 0, 32'h0,        0, 0, 0, 9, 1, 32'h0,        1, 0, 0, 32'h0,        1, 32'h0};
        tbl[14] = '{0, 0, 0, 32'h0,        0, 0, 1, 9, 1, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0};
        tbl[15] = '{0, 0, 0, 32'h0,        0, 0, 0, 9, 1, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        tbl[16] = '{1, 1, 2, 32'hABCD,     0, 0, 0, 2, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        tbl[17] = '{0, 0, 0, 32'h0,        0, 0, 0, 2, 1, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};
        tbl[18] = '{0, 0, 0, 32'h0,        0, 0, 0, 5, 1, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0};

        @(negedge clk);
        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rsv_en = tbl[i].rsv; rsv_addr = tbl[i].ra; sb_flush = tbl[i].fl;
            rdA_addr[0] = tbl[i].rd; rdA_addr[1] = tbl[i].rd;
            rdB_addr[0] = tbl[i].rd; rdB_addr[1] = 5'd20; rdB_addr[2] = 5'd30;
            #2;
            if (tbl[i].chk) begin
                check($sformatf("v%0d_rd_data", i), rdA_data[0], tbl[i].e_rd);
                check($sformatf("v%0d_rd_busy", i), {31'b0, rdA_busy[0]}, {31'b0, tbl[i].e_busy});
                check($sformatf("v%0d_trc_valid", i), {31'b0, trcA_valid}, {31'b0, tbl[i].e_tv});
                if (tbl[i].e_tv) begin
                    check($sformatf("v%0d_trc_addr", i), {27'b0, trcA_addr}, {27'b0, tbl[i].e_ta});
                    check($sformatf("v%0d_trc_data", i), trcA_data, tbl[i].e_td);
                end
                check($sformatf("v%0d_err_waw", i), {31'b0, errA}, {31'b0, tbl[i].e_err});
                check($sformatf("v%0d_b_rd_data", i), rdB_data[0], tbl[i].e_rdb);
            end
            cycle();
        end

        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            wr_en    = $urandom_range(0, 1) != 0;
            wr_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wr_data  = $urandom;
            rsv_en   = $urandom_range(0, 2) == 0;
            rsv_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            sb_flush = $urandom_range(0, 31) == 0;
            for (int p = 0; p < 2; p++)
                rdA_addr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++)
                rdB_addr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
